// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with parallel load, synchronous clear, cascade tc and wrap/ovf flags.
// Build option: define MOD_UPDOWN_COUNTER_SATURATE_EN to pin at the bounds instead of wrapping.
module mod_updown_counter #(
   parameter int unsigned     WIDTH     = 4,
   parameter longint unsigned MODULUS   = 16,
   parameter longint unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             en,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
   localparam logic [WIDTH:0]   ONE_EXT = (WIDTH+1)'(1);
   localparam logic [WIDTH:0]   TOP_EXT = MOD_EXT - ONE_EXT;
   localparam logic [WIDTH-1:0] TOP     = TOP_EXT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RST     = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH:0]   q_ext, inc, dec;
   logic             up_cross, dn_cross, crossing;

   // One extra bit keeps q+1 == MODULUS exact when MODULUS == 2^WIDTH.
   assign q_ext    = {1'b0, q_q};
   assign inc      = q_ext + ONE_EXT;
   assign dec      = q_ext - ONE_EXT;
   assign up_cross = (inc == MOD_EXT);
   assign dn_cross = dec[WIDTH];
   assign crossing = up ? up_cross : dn_cross;

   assign tc   = en & crossing;
   assign q    = q_q;
   assign wrap = wrap_q;
   assign ovf  = ovf_q;

   always_comb begin
      q_d    = q_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q;
      if (clr) begin
         q_d   = RST;
         ovf_d = 1'b0;
      end else if (load) begin
         q_d = ({1'b0, din} > TOP_EXT) ? TOP : din;
      end else if (en) begin
         if (crossing) begin
            wrap_d = 1'b1;
            ovf_d  = 1'b1;
`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
            q_d    = q_q;
`else
            q_d    = up ? '0 : TOP;
`endif
         end else begin
            q_d = up ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q    <= RST;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         q_q    <= q_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

endmodule
